// File: rtl/decoder_4to16_if.sv
// rtl/decoder_4to16_if.sv - select/line bundle for the registered 4-to-16 decoder
interface decoder_4to16_if;
  logic        en;
  logic        W;
  logic        X;
  logic        Y;
  logic        Z;
  logic [15:0] D;
  logic        valid;
  logic [3:0]  sel_q;

  modport master (output en, W, X, Y, Z, input D, valid, sel_q);
  modport slave  (input en, W, X, Y, Z, output D, valid, sel_q);
endinterface

// File: rtl/decoder_4to16.sv
// rtl/decoder_4to16.sv - registered 4-to-16 one-hot decoder, all outputs from flops
// Optional DECODER_4TO16_ACTIVE_LOW_EN makes D0..D15 active-low.
module decoder_4to16 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       W,
  input  logic       X,
  input  logic       Y,
  input  logic       Z,
  output logic       D0,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5,
  output logic       D6,
  output logic       D7,
  output logic       D8,
  output logic       D9,
  output logic       D10,
  output logic       D11,
  output logic       D12,
  output logic       D13,
  output logic       D14,
  output logic       D15,
  output logic       valid,
  output logic [3:0] sel_q
);

`ifdef DECODER_4TO16_ACTIVE_LOW_EN
  localparam logic [15:0] LINE_IDLE = 16'hFFFF;
`else
  localparam logic [15:0] LINE_IDLE = 16'h0000;
`endif

  logic [3:0]  sel_in;
  logic [15:0] lines_q;
  logic [15:0] lines_d;
  logic        valid_q;
  logic        valid_d;
  logic [3:0]  sel_d;

  assign sel_in = {W, X, Y, Z};

  // Polarity is folded in before the flop so every output pin is a flop Q.
  always_comb begin
    lines_d = LINE_IDLE;
    valid_d = 1'b0;
    sel_d   = sel_q;
    if (en) begin
      lines_d = (16'h0001 << sel_in) ^ LINE_IDLE;
      valid_d = 1'b1;
      sel_d   = sel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lines_q <= LINE_IDLE;
      valid_q <= 1'b0;
      sel_q   <= 4'b0000;
    end else begin
      lines_q <= lines_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign valid = valid_q;
  assign {D15, D14, D13, D12, D11, D10, D9, D8,
          D7,  D6,  D5,  D4,  D3,  D2,  D1, D0} = lines_q;

endmodule

// File: tb/tb_decoder_4to16.sv
// tb/tb_decoder_4to16.sv - directed and random checks for decoder_4to16
`timescale 1ns/1ps
module tb_decoder_4to16;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_4to16_if bus ();

  logic [15:0] d_obs;
  logic        valid_obs;
  logic [3:0]  sel_obs;
  int          checks = 0;
  int          errors = 0;

`ifdef DECODER_4TO16_ACTIVE_LOW_EN
  localparam logic [15:0] POL = 16'hFFFF;
`else
  localparam logic [15:0] POL = 16'h0000;
`endif

  decoder_4to16 dut (
    .clk(clk), .rst_n(rst_n), .en(bus.en),
    .W(bus.W), .X(bus.X), .Y(bus.Y), .Z(bus.Z),
    .D0(d_obs[0]),   .D1(d_obs[1]),   .D2(d_obs[2]),   .D3(d_obs[3]),
    .D4(d_obs[4]),   .D5(d_obs[5]),   .D6(d_obs[6]),   .D7(d_obs[7]),
    .D8(d_obs[8]),   .D9(d_obs[9]),   .D10(d_obs[10]), .D11(d_obs[11]),
    .D12(d_obs[12]), .D13(d_obs[13]), .D14(d_obs[14]), .D15(d_obs[15]),
    .valid(valid_obs), .sel_q(sel_obs)
  );

  assign bus.D     = d_obs;
  assign bus.valid = valid_obs;
  assign bus.sel_q = sel_obs;

  task automatic drive(input logic e, input logic [3:0] s);
    bus.en = e;
    {bus.W, bus.X, bus.Y, bus.Z} = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'b1010);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (d_obs !== POL) begin
        errors++; $display("FAIL reset_lines cycle %0d: got %h expected %h", c, d_obs, POL);
      end
      checks++;
      if (valid_obs !== 1'b0) begin
        errors++; $display("FAIL reset_valid cycle %0d: got %b expected 0", c, valid_obs);
      end
      checks++;
      if (sel_obs !== 4'b0000) begin
        errors++; $display("FAIL reset_sel cycle %0d: got %b expected 0000", c, sel_obs);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [15:0] exp;
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 4'(n));
      tick();
      exp = (16'h0001 << n) ^ POL;
      checks++;
      if (d_obs !== exp) begin
        errors++; $display("FAIL sweep_lines n=%0d: got %h expected %h", n, d_obs, exp);
      end
      checks++;
      if (valid_obs !== 1'b1) begin
        errors++; $display("FAIL sweep_valid n=%0d: got %b expected 1", n, valid_obs);
      end
      checks++;
      if (sel_obs !== 4'(n)) begin
        errors++; $display("FAIL sweep_sel n=%0d: got %0d expected %0d", n, sel_obs, n);
      end
    end
    drive(1'b1, 4'b1101);
    tick();
    checks++;
    if (d_obs !== (16'h2000 ^ POL)) begin
      errors++; $display("FAIL sweep_d13: got %h expected %h", d_obs, 16'h2000 ^ POL);
    end
  endtask

  task automatic test_enable_gating();
    drive(1'b1, 4'b0110);
    tick();
    checks++;
    if (d_obs !== (16'h0040 ^ POL)) begin
      errors++; $display("FAIL gate_d6: got %h expected %h", d_obs, 16'h0040 ^ POL);
    end
    drive(1'b0, 4'b1001);
    tick();
    checks++;
    if (d_obs !== POL) begin
      errors++; $display("FAIL gate_lines: got %h expected %h", d_obs, POL);
    end
    checks++;
    if (valid_obs !== 1'b0) begin
      errors++; $display("FAIL gate_valid: got %b expected 0", valid_obs);
    end
    checks++;
    if (sel_obs !== 4'b0110) begin
      errors++; $display("FAIL gate_sel_hold: got %b expected 0110", sel_obs);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 4'b1111);
    tick();
    checks++;
    if (d_obs !== (16'h8000 ^ POL)) begin
      errors++; $display("FAIL mid_d15: got %h expected %h", d_obs, 16'h8000 ^ POL);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (d_obs !== POL || valid_obs !== 1'b0 || sel_obs !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: got lines %h valid %b sel %b expected %h 0 0000",
                         d_obs, valid_obs, sel_obs, POL);
    end
    rst_n = 1'b1;
    drive(1'b1, 4'b0011);
    tick();
    checks++;
    if (d_obs !== (16'h0008 ^ POL) || valid_obs !== 1'b1 || sel_obs !== 4'b0011) begin
      errors++; $display("FAIL mid_release_d3: got lines %h valid %b sel %b expected %h 1 0011",
                         d_obs, valid_obs, sel_obs, 16'h0008 ^ POL);
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 4'b0100);
    tick();
    checks++;
    if (d_obs !== (16'h0010 ^ POL)) begin
      errors++; $display("FAIL lat_d4: got %h expected %h", d_obs, 16'h0010 ^ POL);
    end
    #3;
    drive(1'b1, 4'b1000);
    for (int t = 0; t < 5; t++) begin
      #1;
      checks++;
      if (d_obs !== (16'h0010 ^ POL)) begin
        errors++; $display("FAIL lat_hold t=%0d: got %h expected %h", t, d_obs, 16'h0010 ^ POL);
      end
    end
    tick();
    checks++;
    if (d_obs !== (16'h0100 ^ POL)) begin
      errors++; $display("FAIL lat_d8: got %h expected %h", d_obs, 16'h0100 ^ POL);
    end
  endtask

  task automatic test_invariant();
    logic        e;
    logic [3:0]  s;
    logic [15:0] exp;
    logic        exp_valid;
    for (int c = 0; c < 1000; c++) begin
      e = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      drive(e, s);
      tick();
      exp       = e ? ((16'h0001 << s) ^ POL) : POL;
      exp_valid = e;
      checks++;
      if ($countones(d_obs ^ POL) !== int'(valid_obs)) begin
        errors++; $display("FAIL onehot_count cycle %0d: got %0d lines valid %b",
                           c, $countones(d_obs ^ POL), valid_obs);
      end
      checks++;
      if (d_obs !== exp || valid_obs !== exp_valid) begin
        errors++; $display("FAIL random_decode cycle %0d: got %h/%b expected %h/%b",
                           c, d_obs, valid_obs, exp, exp_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep();
    test_enable_gating();
    test_reset_midstream();
    test_latency();
    test_invariant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
